// File: rtl/rhd_convert_sequencer.sv
// RHD2164 command sequencer: per trigger issues N CONVERTs plus two dummy READs through the
// SPI master and streams the pipelined A/B results as channel-tagged samples.
module rhd_convert_sequencer #(
   parameter int unsigned CS_SETUP_CLKS = 2,
   parameter int unsigned CS_HIGH_CLKS  = 8,
   parameter logic [15:0] DUMMY_CMD     = 16'hE800
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_trig,
   input  logic [5:0]  i_num_ch,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic        o_trig_miss,
   output logic        o_cs_n,
   output logic        o_spi_start,
   output logic [15:0] o_spi_din,
   input  logic        i_spi_done,
   input  logic [15:0] i_spi_dout_a,
   input  logic [15:0] i_spi_dout_b,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [4:0]  o_chan,
   output logic [15:0] o_data_a,
   output logic [15:0] o_data_b,
   output logic        o_overflow
);

   typedef enum logic [2:0] {StIdle, StSetup, StStart, StWait, StHold} state_e;

   state_e      state_q, state_d;
   logic [5:0]  n_q, n_d;
   logic [5:0]  k_q, k_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] din_q, din_d;
   logic        valid_q, valid_d;
   logic [4:0]  chan_q, chan_d;
   logic [15:0] data_a_q, data_a_d;
   logic [15:0] data_b_q, data_b_d;
   logic        overflow_q, overflow_d;
   logic        frame_done_q, frame_done_d;
   logic        trig_miss_q, trig_miss_d;
   logic [5:0]  n_clamped;
   logic        load;

   function automatic logic [15:0] cmd_for(input logic [5:0] k, input logic [5:0] n);
      if (k < n) begin
         return {2'b00, k, 8'h00};
      end
      return DUMMY_CMD;
   endfunction

   always_comb begin
      if (i_num_ch == 6'd0) begin
         n_clamped = 6'd1;
      end else if (i_num_ch > 6'd32) begin
         n_clamped = 6'd32;
      end else begin
         n_clamped = i_num_ch;
      end
   end

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      k_d          = k_q;
      cnt_d        = cnt_q;
      din_d        = din_q;
      valid_d      = valid_q;
      chan_d       = chan_q;
      data_a_d     = data_a_q;
      data_b_d     = data_b_q;
      overflow_d   = overflow_q;
      frame_done_d = 1'b0;
      trig_miss_d  = i_trig & (state_q != StIdle);
      load         = 1'b0;

      if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (i_enable && i_trig && i_spi_done) begin
               n_d        = n_clamped;
               k_d        = 6'd0;
               cnt_d      = 8'd0;
               overflow_d = 1'b0;
               din_d      = cmd_for(6'd0, n_clamped);
               state_d    = StSetup;
            end
         end
         StSetup: begin
            if (cnt_q == 8'(CS_SETUP_CLKS - 1)) begin
               cnt_d   = 8'd0;
               state_d = StStart;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StStart: begin
            cnt_d   = 8'd0;
            state_d = StWait;
         end
         StWait: begin
            // The master's done is still high from the previous transfer in the first cycle.
            if (cnt_q == 8'd0) begin
               cnt_d = 8'd1;
            end else if (i_spi_done) begin
               load    = (k_q >= 6'd2);
               cnt_d   = 8'd0;
               state_d = StHold;
            end
         end
         StHold: begin
            if (cnt_q == 8'(CS_HIGH_CLKS - 1)) begin
               cnt_d = 8'd0;
               if (k_q == n_q + 6'd1) begin
                  frame_done_d = 1'b1;
                  state_d      = StIdle;
               end else if (!i_enable) begin
                  state_d = StIdle;
               end else begin
                  k_d     = k_q + 6'd1;
                  din_d   = cmd_for(k_q + 6'd1, n_q);
                  state_d = StSetup;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Results lag commands by two transfers.
      if (load) begin
         valid_d  = 1'b1;
         chan_d   = 5'(k_q - 6'd2);
         data_a_d = i_spi_dout_a;
         data_b_d = i_spi_dout_b;
         if (valid_q && !i_ready) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= StIdle;
         n_q          <= 6'd0;
         k_q          <= 6'd0;
         cnt_q        <= 8'd0;
         din_q        <= 16'd0;
         valid_q      <= 1'b0;
         chan_q       <= 5'd0;
         data_a_q     <= 16'd0;
         data_b_q     <= 16'd0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
         trig_miss_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         k_q          <= k_d;
         cnt_q        <= cnt_d;
         din_q        <= din_d;
         valid_q      <= valid_d;
         chan_q       <= chan_d;
         data_a_q     <= data_a_d;
         data_b_q     <= data_b_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
         trig_miss_q  <= trig_miss_d;
      end
   end

   assign o_cs_n       = !((state_q == StSetup) || (state_q == StStart) || (state_q == StWait));
   assign o_spi_start  = (state_q == StStart);
   assign o_spi_din    = din_q;
   assign o_busy       = (state_q != StIdle);
   assign o_frame_done = frame_done_q;
   assign o_trig_miss  = trig_miss_q;
   assign o_valid      = valid_q;
   assign o_chan       = chan_q;
   assign o_data_a     = data_a_q;
   assign o_data_b     = data_b_q;
   assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_rhd_convert_sequencer.sv
// Bench for rhd_convert_sequencer: behavioural SPI master plus command and sample scoreboards.
module tb_rhd_convert_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        trig = 1'b0;
   logic [5:0]  num_ch = 6'd0;
   logic        spi_done;
   logic [15:0] dout_a;
   logic [15:0] dout_b;
   logic        ready = 1'b1;

   logic        o_busy, o_frame_done, o_trig_miss, o_cs_n, o_spi_start;
   logic [15:0] o_spi_din;
   logic        o_valid;
   logic [4:0]  o_chan;
   logic [15:0] o_data_a, o_data_b;
   logic        o_overflow;

   int tests_run = 0;
   int tests_failed = 0;
   int n_xfer = 0;
   int n_samples = 0;
   int n_done = 0;
   int n_miss = 0;
   int xfer_k = 0;
   int last_chan = -1;

   logic [15:0] cmd_q[$];
   logic [36:0] smp_q[$];

   rhd_convert_sequencer dut (
      .i_clk        (clk),
      .i_rst        (rst_n),
      .i_enable     (enable),
      .i_trig       (trig),
      .i_num_ch     (num_ch),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done),
      .o_trig_miss  (o_trig_miss),
      .o_cs_n       (o_cs_n),
      .o_spi_start  (o_spi_start),
      .o_spi_din    (o_spi_din),
      .i_spi_done   (spi_done),
      .i_spi_dout_a (dout_a),
      .i_spi_dout_b (dout_b),
      .o_valid      (o_valid),
      .i_ready      (ready),
      .o_chan       (o_chan),
      .o_data_a     (o_data_a),
      .o_data_b     (o_data_b),
      .o_overflow   (o_overflow)
   );

   always #5 clk = ~clk;

   // SPI master model: drops done one cycle after start, returns tagged words later.
   initial begin : master
      logic [15:0] exp_cmd;
      int idx;
      spi_done = 1'b1;
      dout_a   = 16'd0;
      dout_b   = 16'd0;
      forever begin
         @(negedge clk);
         if (rst_n && o_spi_start) begin
            n_xfer++;
            idx = xfer_k;
            xfer_k++;
            tests_run++;
            if (cmd_q.size() == 0) begin
               tests_failed++;
               $display("FAIL cmd_unexpected: got %h, want no transfer", o_spi_din);
            end else begin
               exp_cmd = cmd_q.pop_front();
               if (o_spi_din !== exp_cmd || o_cs_n !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL cmd[%0d]: got din=%h cs_n=%b, want din=%h cs_n=0",
                           idx, o_spi_din, o_cs_n, exp_cmd);
               end
            end
            @(posedge clk);
            #1 spi_done = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            dout_a   = {8'hA0, 8'(idx)};
            dout_b   = {8'hB0, 8'(idx)};
            spi_done = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      logic [36:0] exp_s;
      if (rst_n && o_valid && ready) begin
         n_samples++;
         last_chan = int'(o_chan);
         tests_run++;
         if (smp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sample_unexpected: got chan=%0d a=%h b=%h, want none",
                     o_chan, o_data_a, o_data_b);
         end else begin
            exp_s = smp_q.pop_front();
            if ({o_chan, o_data_a, o_data_b} !== exp_s) begin
               tests_failed++;
               $display("FAIL sample: got chan=%0d a=%h b=%h, want chan=%0d a=%h b=%h",
                        o_chan, o_data_a, o_data_b, exp_s[36:32], exp_s[31:16], exp_s[15:0]);
            end
         end
      end
      if (rst_n && o_frame_done) n_done++;
      if (rst_n && o_trig_miss) n_miss++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish before 500us");
      $fatal(1, "watchdog");
   end

   task automatic clear_counts();
      n_xfer    = 0;
      n_samples = 0;
      n_done    = 0;
      n_miss    = 0;
      xfer_k    = 0;
      last_chan = -1;
   endtask

   task automatic push_frame(input int n, input bit with_samples);
      for (int k = 0; k < n; k++) cmd_q.push_back(16'(k) << 8);
      cmd_q.push_back(16'hE800);
      cmd_q.push_back(16'hE800);
      if (with_samples) begin
         for (int i = 0; i < n; i++) begin
            smp_q.push_back({5'(i), 8'hA0, 8'(i + 2), 8'hB0, 8'(i + 2)});
         end
      end
   endtask

   task automatic pulse_trig();
      @(posedge clk);
      #1 trig = 1'b1;
      @(posedge clk);
      #1 trig = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!o_busy) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      #12;
      tests_run++;
      if ({o_cs_n, o_spi_start, o_busy, o_frame_done, o_trig_miss} !== 5'b10000) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b, want 10000",
                  {o_cs_n, o_spi_start, o_busy, o_frame_done, o_trig_miss});
      end
      tests_run++;
      if ({o_valid, o_overflow, o_chan} !== 7'd0) begin
         tests_failed++;
         $display("FAIL reset_stream: got valid=%b ovf=%b chan=%0d, want 0 0 0",
                  o_valid, o_overflow, o_chan);
      end
      tests_run++;
      if ({o_spi_din, o_data_a, o_data_b} !== 48'd0) begin
         tests_failed++;
         $display("FAIL reset_data: got din=%h a=%h b=%h, want 0 0 0",
                  o_spi_din, o_data_a, o_data_b);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      enable = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_basic();
      bit ok;
      clear_counts();
      ready  = 1'b1;
      num_ch = 6'd4;
      push_frame(4, 1'b1);
      pulse_trig();
      wait_idle(ok);
      tests_run++;
      if (ok !== 1'b1 || n_xfer != 6 || n_samples != 4 || n_done != 1) begin
         tests_failed++;
         $display("FAIL basic_counts: got ok=%b xfer=%0d smp=%0d done=%0d, want 1 6 4 1",
                  ok, n_xfer, n_samples, n_done);
      end
      tests_run++;
      if (o_overflow !== 1'b0 || o_cs_n !== 1'b1 || last_chan != 3) begin
         tests_failed++;
         $display("FAIL basic_end: got ovf=%b cs_n=%b last=%0d, want 0 1 3",
                  o_overflow, o_cs_n, last_chan);
      end
   endtask

   task automatic test_clamp();
      bit ok;
      clear_counts();
      num_ch = 6'd0;
      push_frame(1, 1'b1);
      pulse_trig();
      wait_idle(ok);
      tests_run++;
      if (ok !== 1'b1 || n_xfer != 3 || n_samples != 1 || last_chan != 0) begin
         tests_failed++;
         $display("FAIL clamp_zero: got ok=%b xfer=%0d smp=%0d last=%0d, want 1 3 1 0",
                  ok, n_xfer, n_samples, last_chan);
      end
      clear_counts();
      num_ch = 6'd40;
      push_frame(32, 1'b1);
      pulse_trig();
      wait_idle(ok);
      tests_run++;
      if (ok !== 1'b1 || n_xfer != 34 || n_samples != 32 || last_chan != 31 || n_done != 1) begin
         tests_failed++;
         $display("FAIL clamp_max: got ok=%b xfer=%0d smp=%0d last=%0d done=%0d, want 1 34 32 31 1",
                  ok, n_xfer, n_samples, last_chan, n_done);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_counts();
      ready  = 1'b0;
      num_ch = 6'd3;
      push_frame(3, 1'b0);
      pulse_trig();
      wait_idle(ok);
      tests_run++;
      if (ok !== 1'b1 || o_valid !== 1'b1 || o_chan !== 5'd2 || o_data_a !== 16'hA004 ||
          o_data_b !== 16'hB004) begin
         tests_failed++;
         $display("FAIL bp_hold: got ok=%b valid=%b chan=%0d a=%h b=%h, want 1 1 2 A004 B004",
                  ok, o_valid, o_chan, o_data_a, o_data_b);
      end
      tests_run++;
      if (o_overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_overflow: got %b, want 1", o_overflow);
      end
      smp_q.push_back({5'd2, 16'hA004, 16'hB004});
      @(posedge clk);
      #1 ready = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (n_samples != 1 || o_valid !== 1'b0 || o_overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_drain: got smp=%0d valid=%b ovf=%b, want 1 0 1",
                  n_samples, o_valid, o_overflow);
      end
      clear_counts();
      num_ch = 6'd1;
      push_frame(1, 1'b1);
      pulse_trig();
      @(negedge clk);
      tests_run++;
      if (o_overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_clear: got ovf=%b, want 0", o_overflow);
      end
      wait_idle(ok);
   endtask

   task automatic test_trig_miss();
      bit ok;
      clear_counts();
      num_ch = 6'd4;
      push_frame(4, 1'b1);
      pulse_trig();
      repeat (20) @(posedge clk);
      pulse_trig();
      wait_idle(ok);
      tests_run++;
      if (ok !== 1'b1 || n_miss != 1 || n_xfer != 6 || n_done != 1 || n_samples != 4) begin
         tests_failed++;
         $display("FAIL trig_miss: got ok=%b miss=%0d xfer=%0d done=%0d smp=%0d, want 1 1 6 1 4",
                  ok, n_miss, n_xfer, n_done, n_samples);
      end
   endtask

   task automatic test_disable();
      bit ok;
      bit seen;
      clear_counts();
      num_ch = 6'd8;
      push_frame(8, 1'b1);
      pulse_trig();
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (n_xfer == 3) begin
            seen = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1 enable = 1'b0;
      wait_idle(ok);
      tests_run++;
      if (seen !== 1'b1 || ok !== 1'b1 || n_xfer != 3 || n_samples != 1 || last_chan != 0) begin
         tests_failed++;
         $display("FAIL disable_run: got seen=%b ok=%b xfer=%0d smp=%0d last=%0d, want 1 1 3 1 0",
                  seen, ok, n_xfer, n_samples, last_chan);
      end
      tests_run++;
      if (n_done != 0 || o_cs_n !== 1'b1 || cmd_q.size() != 7 || smp_q.size() != 7) begin
         tests_failed++;
         $display("FAIL disable_end: got done=%0d cs_n=%b cmdq=%0d smpq=%0d, want 0 1 7 7",
                  n_done, o_cs_n, cmd_q.size(), smp_q.size());
      end
      cmd_q.delete();
      smp_q.delete();
      @(posedge clk);
      #1 enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      clear_counts();
      num_ch = 6'd4;
      push_frame(4, 1'b1);
      pulse_trig();
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (n_xfer == 1) begin
            seen = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      tests_run++;
      if (seen !== 1'b1 || o_cs_n !== 1'b1 || o_busy !== 1'b0 || o_spi_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_ctrl: got seen=%b cs_n=%b busy=%b start=%b, want 1 1 0 0",
                  seen, o_cs_n, o_busy, o_spi_start);
      end
      tests_run++;
      if ({o_spi_din, o_valid, o_chan, o_data_a, o_data_b, o_overflow} !== 55'd0) begin
         tests_failed++;
         $display("FAIL rst_mid_data: got din=%h valid=%b chan=%0d a=%h, want all zero",
                  o_spi_din, o_valid, o_chan, o_data_a);
      end
      cmd_q.delete();
      smp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (spi_done) break;
      end
      clear_counts();
      num_ch = 6'd2;
      push_frame(2, 1'b1);
      pulse_trig();
      wait_idle(ok);
      tests_run++;
      if (ok !== 1'b1 || n_xfer != 4 || n_samples != 2 || n_done != 1 || cmd_q.size() != 0) begin
         tests_failed++;
         $display("FAIL rst_rerun: got ok=%b xfer=%0d smp=%0d done=%0d cmdq=%0d, want 1 4 2 1 0",
                  ok, n_xfer, n_samples, n_done, cmd_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_backpressure();
      test_trig_miss();
      test_disable();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/rhd_convert_sequencer.md
Name: rhd_convert_sequencer

Overview:
- Command sequencer directly upstream of the SPI master that talks to the RHD2164.
- On each trigger, runs one sampling frame: N CONVERT commands, then 2 dummy READ commands to flush the chip's 2-command result pipeline.
- Drives chip-select, start and command word; collects the DDR A/B result words.
- Presents results as a channel-tagged valid/ready sample stream.

Parameters:
- CS_SETUP_CLKS, 2, i_clk cycles CS held low before the start pulse (1..255).
- CS_HIGH_CLKS, 8, i_clk cycles CS held high after each transfer (1..255).
- DUMMY_CMD, 16'hE800, dummy command word: READ(40).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-low reset
- i_enable  in  1  sequencer enable
- i_trig  in  1  frame trigger pulse
- i_num_ch  in  6  channels per frame; 0 treated as 1, >32 clamped to 32; latched at frame start
- o_busy  out  1  frame in progress
- o_frame_done  out  1  one-cycle pulse at normal frame completion
- o_trig_miss  out  1  one-cycle pulse when i_trig arrives while busy
- o_cs_n  out  1  RHD chip select, active low
- o_spi_start  out  1  one-cycle start pulse to the SPI master
- o_spi_din  out  16  command word; stable from start pulse to end of transfer
- i_spi_done  in  1  SPI master ready/done, including its post-done wait
- i_spi_dout_a  in  16  received word, MISO A
- i_spi_dout_b  in  16  received word, MISO B
- o_valid  out  1  sample valid
- i_ready  in  1  sample accepted when o_valid & i_ready
- o_chan  out  5  channel index of the sample
- o_data_a  out  16  MISO A result
- o_data_b  out  16  MISO B result
- o_overflow  out  1  sticky: an unaccepted sample was overwritten; cleared at frame start

Behaviour:
- Reset values (async, i_rst=0): o_cs_n=1; o_spi_start=0; o_spi_din=0; o_valid=0; o_chan=0; o_data_a/b=0; o_busy=0; o_frame_done=0; o_trig_miss=0; o_overflow=0; FSM in IDLE; counters 0.
- Reset mid-frame aborts immediately; CS goes high on reset assertion.
- States: IDLE, SETUP, START, WAIT, HOLD.
- IDLE:
  - i_enable & i_trig & i_spi_done -> latch N (clamped); k=0; clear o_overflow; o_busy=1; go SETUP.
  - Trigger while i_spi_done=0 is ignored.
- SETUP:
  - o_cs_n=0.
  - o_spi_din = CONVERT(k) = {2'b00, k[5:0], 8'h00} for k<N; DUMMY_CMD for k>=N.
  - Count CS_SETUP_CLKS cycles -> START.
- START: o_spi_start=1 for exactly one cycle -> WAIT.
- WAIT:
  - Ignore i_spi_done in the first WAIT cycle, since the master drops done one cycle after start.
  - From the second cycle on, i_spi_done=1 -> capture i_spi_dout_a/b that cycle -> HOLD.
- HOLD:
  - o_cs_n=1 for CS_HIGH_CLKS cycles.
  - Then: if k==N+1 -> IDLE with o_frame_done pulse, o_busy=0.
  - Else if i_enable=0 -> IDLE, no frame_done, o_busy=0.
  - Else k=k+1 -> SETUP.
- Result tagging:
  - Transfer k>=2 carries the result of CONVERT(k-2): load o_chan=k-2, o_data_a/b, o_valid=1 on the cycle after capture.
  - Results of transfers 0 and 1 are discarded.
  - A frame of N channels produces exactly N samples, chan 0..N-1 in order.
- Output handshake:
  - o_valid stays high until o_valid & i_ready.
  - A new load in the same cycle as acceptance replaces the sample; o_valid stays 1, no overflow.
  - A new load while o_valid & ~i_ready overwrites the sample and sets o_overflow.
- Triggers: i_trig while o_busy=1 -> o_trig_miss one-cycle pulse; frame unaffected.
- Disable mid-frame: the current transfer completes including HOLD; its pending sample is still emitted; later commands are not issued.
- Transfer period: CS_SETUP_CLKS + 1 + SPI transfer time + CS_HIGH_CLKS cycles.
- Frame length: N+2 transfers.

Test Plan:
- N=4, trigger, i_ready=1, model master returns dout_a={8'hA0,k}, dout_b={8'hB0,k} -> commands 0000,0100,0200,0300,E800,E800; samples chan 0..3 with data_a=A002..A005; one frame_done; overflow=0.
- i_num_ch=0 and i_num_ch=40 -> 3 transfers / 1 sample, and 34 transfers / 32 samples (chan 31 last).
- i_ready=0 for a whole N=3 frame -> o_valid held; final sample chan=2; o_overflow=1; next trigger clears o_overflow.
- Second i_trig mid-frame -> o_trig_miss one pulse; transfer count for the frame remains N+2.
- i_enable dropped during transfer k=2 of an N=8 frame -> transfer 2 completes; sample chan 0 emitted; CS high; IDLE; no frame_done.
- i_rst asserted during WAIT -> o_cs_n=1 and all outputs at reset values asynchronously; new trigger after release runs a full frame.
